// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined SLL/SRL/SRA(/ROL) barrel shifter with valid/ready handshake
//
// Purpose:
//   Shifts in_data by in_shamt through SHAMT_W mux levels. Level k shifts by 2^k when
//   shamt[k] is set, and the LSB level comes first. A register stage follows every
//   REG_EVERY levels, giving STAGES = ceil(SHAMT_W / REG_EVERY) cycles of latency.
//   Each stage carries its valid bit, partial data, shift amount, op, SRA sign and tag.
//   Stalls propagate backwards combinationally, and empty stages (bubbles) collapse.
//
// Optional feature:
//   SHIFTER_ROTATE_EN defined   -> op 2'b11 is rotate-left.
//   SHIFTER_ROTATE_EN undefined -> op 2'b11 behaves as SLL, and no rotate muxes exist.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   async active-high reset, clears the whole pipeline
//   in_valid   in   operation presented
//   in_ready   out  shifter accepts this cycle
//   in_data    in   operand (WIDTH)
//   in_shamt   in   shift amount (SHAMT_W)
//   in_op      in   00 SLL, 01 SRL, 10 SRA, 11 ROL or SLL
//   in_tag     in   sideband tag, returned unchanged (TAG_W)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  shifted result (WIDTH)
//   out_tag    out  tag of this result (TAG_W)

module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = 5,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int STAGES = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [1:0] OP_ROL = 2'b11;
`endif

    // Stage registers
    logic [STAGES-1:0]  st_valid;
    logic [WIDTH-1:0]   st_data  [STAGES];
    logic [SHAMT_W-1:0] st_shamt [STAGES];
    logic [1:0]         st_op    [STAGES];
    logic               st_sign  [STAGES];
    logic [TAG_W-1:0]   st_tag   [STAGES];

    // What each stage would load: the input ports for stage 0, the previous stage otherwise
    logic [STAGES-1:0]  src_valid;
    logic [WIDTH-1:0]   src_data  [STAGES];
    logic [SHAMT_W-1:0] src_shamt [STAGES];
    logic [1:0]         src_op    [STAGES];
    logic               src_sign  [STAGES];
    logic [TAG_W-1:0]   src_tag   [STAGES];
    logic [WIDTH-1:0]   nxt_data  [STAGES];

    // stage_ready[i]: stage i may load this cycle; stage_ready[STAGES] is the consumer
    logic [STAGES:0]    stage_ready;
    logic [STAGES-1:0]  stage_adv;

    // One mux level: shift by 2^k with the fill selected by the op
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic [1:0]       op,
        input logic             sign
    );
        int               sh;
        logic [WIDTH-1:0] fill_mask;
        sh        = 1 << k;
        fill_mask = ~({WIDTH{1'b1}} >> sh);
        case (op)
            OP_SRL:  shift_level = d >> sh;
            OP_SRA:  shift_level = (d >> sh) | (sign ? fill_mask : '0);
`ifdef SHIFTER_ROTATE_EN
            OP_ROL:  shift_level = (d << sh) | (d >> (WIDTH - sh));
`endif
            default: shift_level = d << sh;
        endcase
    endfunction

    // Backpressure chain: a stage can load if it is empty or its content leaves this cycle
    always_comb begin
        stage_ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            stage_adv[i]   = st_valid[i] && stage_ready[i+1];
            stage_ready[i] = !st_valid[i] || stage_adv[i];
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt;
        src_op[0]    = in_op;
        src_sign[0]  = in_data[WIDTH-1];
        src_tag[0]   = in_tag;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = st_valid[i-1];
            src_data[i]  = st_data[i-1];
            src_shamt[i] = st_shamt[i-1];
            src_op[i]    = st_op[i-1];
            src_sign[i]  = st_sign[i-1];
            src_tag[i]   = st_tag[i-1];
        end
    end

    // Stage i applies levels i*REG_EVERY .. min((i+1)*REG_EVERY, SHAMT_W)-1
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            nxt_data[i] = src_data[i];
            for (int k = i * REG_EVERY; (k < (i + 1) * REG_EVERY) && (k < SHAMT_W); k++) begin
                if (src_shamt[i][k]) begin
                    nxt_data[i] = shift_level(nxt_data[i], k, src_op[i], src_sign[i]);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_data[i]  <= '0;
                st_shamt[i] <= '0;
                st_op[i]    <= '0;
                st_sign[i]  <= 1'b0;
                st_tag[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (stage_ready[i]) begin
                    st_valid[i] <= src_valid[i];
                    // Payload only moves with a real op, so bubbles leave it untouched
                    if (src_valid[i]) begin
                        st_data[i]  <= nxt_data[i];
                        st_shamt[i] <= src_shamt[i];
                        st_op[i]    <= src_op[i];
                        st_sign[i]  <= src_sign[i];
                        st_tag[i]   <= src_tag[i];
                    end
                end
            end
        end
    end

    // While reset is held, anything presented would be discarded, so do not advertise ready
    assign in_ready  = stage_ready[0] && !reset;
    assign out_valid = st_valid[STAGES-1];
    assign out_data  = st_data[STAGES-1];
    assign out_tag   = st_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - directed self-checking bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;

    localparam int S1 = 5;
    localparam int S2 = 3;
    localparam int S3 = 2;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [31:0] ROL1_EXP  = 32'h0000_0003;
    localparam logic [31:0] ROL12_EXP = 32'h4567_8123;
    localparam logic [7:0]  ROL8_EXP  = 8'h03;
`else
    localparam logic [31:0] ROL1_EXP  = 32'h0000_0002;
    localparam logic [31:0] ROL12_EXP = 32'h4567_8000;
    localparam logic [7:0]  ROL8_EXP  = 8'h02;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic [3:0]  in_tag, out_tag;

    logic        in_ready2, out_valid2, out_ready2;
    logic [31:0] out_data2;
    logic [3:0]  out_tag2;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_data8, out_data8;
    logic [2:0]  in_shamt8;
    logic [1:0]  in_op8;
    logic [3:0]  in_tag8, out_tag8;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat1, lat2, lat8;
    logic [31:0] res1, res2;
    logic [7:0]  res8;
    logic [3:0]  tag1, tag8;

    always #5 clock = ~clock;

    pipelined_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .REG_EVERY(1), .TAG_W(4)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .REG_EVERY(2), .TAG_W(4)) u_dut_re2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_shamt(in_shamt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_tag(out_tag2)
    );

    pipelined_barrel_shifter #(.WIDTH(8), .SHAMT_W(3), .REG_EVERY(2), .TAG_W(4)) u_dut_w8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_shamt(in_shamt8),
        .in_op(in_op8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_tag(out_tag8)
    );

    task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                          input logic [3:0] tg);
        @(negedge clock);
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op; in_tag = tg;
        lat1 = -1; lat2 = -1; res1 = '0; res2 = '0; tag1 = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (out_valid && lat1 < 0) begin lat1 = cyc; res1 = out_data; tag1 = out_tag; end
            if (out_valid2 && lat2 < 0) begin lat2 = cyc; res2 = out_data2; end
        end
    endtask

    task automatic run_op8(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op,
                           input logic [3:0] tg);
        @(negedge clock);
        in_valid8 = 1'b1; in_data8 = d; in_shamt8 = sh; in_op8 = op; in_tag8 = tg;
        lat8 = -1; res8 = '0; tag8 = '0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clock);
            in_valid8 = 1'b0;
            if (out_valid8 && lat8 < 0) begin lat8 = cyc; res8 = out_data8; tag8 = out_tag8; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h want 0", out_tag); else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_latency();
        run_op(32'h0000_0001, 5'd31, 2'b00, 4'hA);
        n_checks++; if (res1 !== 32'h8000_0000) $display("FAIL sll31_data: got %h want 80000000", res1); else n_pass++;
        n_checks++; if (lat1 !== S1) $display("FAIL sll31_latency: got %0d want %0d", lat1, S1); else n_pass++;
        n_checks++; if (tag1 !== 4'hA) $display("FAIL sll31_tag: got %h want a", tag1); else n_pass++;
        n_checks++; if (res2 !== 32'h8000_0000) $display("FAIL re2_sll31_data: got %h want 80000000", res2); else n_pass++;
        n_checks++; if (lat2 !== S2) $display("FAIL re2_sll31_latency: got %0d want %0d", lat2, S2); else n_pass++;
    endtask

    task automatic test_ops();
        run_op(32'h8000_0000, 5'd4, 2'b10, 4'h1);
        n_checks++; if (res1 !== 32'hF800_0000) $display("FAIL sra4_data: got %h want f8000000", res1); else n_pass++;
        n_checks++; if (res2 !== 32'hF800_0000) $display("FAIL re2_sra4_data: got %h want f8000000", res2); else n_pass++;
        run_op(32'h8000_0000, 5'd4, 2'b01, 4'h2);
        n_checks++; if (res1 !== 32'h0800_0000) $display("FAIL srl4_data: got %h want 08000000", res1); else n_pass++;
        run_op(32'hDEAD_BEEF, 5'd0, 2'b00, 4'h3);
        n_checks++; if (res1 !== 32'hDEAD_BEEF) $display("FAIL sll0_data: got %h want deadbeef", res1); else n_pass++;
        run_op(32'hDEAD_BEEF, 5'd0, 2'b10, 4'h4);
        n_checks++; if (res1 !== 32'hDEAD_BEEF) $display("FAIL sra0_data: got %h want deadbeef", res1); else n_pass++;
        run_op(32'h8000_0000, 5'd17, 2'b10, 4'h5);
        n_checks++; if (res1 !== 32'hFFFF_C000) $display("FAIL sra17_data: got %h want ffffc000", res1); else n_pass++;
        n_checks++; if (res2 !== 32'hFFFF_C000) $display("FAIL re2_sra17_data: got %h want ffffc000", res2); else n_pass++;
        run_op(32'h7000_0000, 5'd4, 2'b10, 4'h6);
        n_checks++; if (res1 !== 32'h0700_0000) $display("FAIL sra_pos_data: got %h want 07000000", res1); else n_pass++;
        run_op(32'h8000_0000, 5'd31, 2'b01, 4'h7);
        n_checks++; if (res1 !== 32'h0000_0001) $display("FAIL srl31_data: got %h want 00000001", res1); else n_pass++;
    endtask

    task automatic test_rotate();
        run_op(32'h8000_0001, 5'd1, 2'b11, 4'h8);
        n_checks++; if (res1 !== ROL1_EXP) $display("FAIL rol1_data: got %h want %h", res1, ROL1_EXP); else n_pass++;
        run_op(32'h1234_5678, 5'd12, 2'b11, 4'h9);
        n_checks++; if (res1 !== ROL12_EXP) $display("FAIL rol12_data: got %h want %h", res1, ROL12_EXP); else n_pass++;
        n_checks++; if (res2 !== ROL12_EXP) $display("FAIL re2_rol12_data: got %h want %h", res2, ROL12_EXP); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int got, first, last, bad, rdy_low;
        logic [3:0] exp_tag;
        got = 0; first = -1; last = -1; bad = 0; rdy_low = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (out_valid) begin
                exp_tag = got[3:0];
                if (first < 0) first = t;
                last = t;
                if (out_tag !== exp_tag || out_data !== (32'h3 << got)) bad++;
                got++;
            end
            if (t < 8) begin
                if (!in_ready) rdy_low++;
                in_valid = 1'b1; in_data = 32'h3; in_shamt = t[4:0]; in_op = 2'b00; in_tag = t[3:0];
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++; if (got !== 8) $display("FAIL b2b_count: got %0d want 8", got); else n_pass++;
        n_checks++; if (first !== S1) $display("FAIL b2b_first_cycle: got %0d want %0d", first, S1); else n_pass++;
        n_checks++; if (last - first !== 7) $display("FAIL b2b_consecutive: got span %0d want 7", last - first); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL b2b_order_data: got %0d bad results want 0", bad); else n_pass++;
        n_checks++; if (rdy_low !== 0) $display("FAIL b2b_in_ready: got %0d stalls want 0", rdy_low); else n_pass++;
    endtask

    task automatic test_stall();
        int next_tag, unstable, have_snap, cnt, bad;
        logic [31:0] snap;
        logic [3:0]  snap_tag, exp_tag;
        next_tag = 0; unstable = 0; have_snap = 0; snap = '0; snap_tag = '0;
        @(negedge clock);
        out_ready = 1'b0;
        for (int t = 0; t < S1 + 4; t++) begin
            if (t > 0) @(negedge clock);
            if (out_valid) begin
                if (have_snap == 0) begin snap = out_data; snap_tag = out_tag; have_snap = 1; end
                else if (out_data !== snap || out_tag !== snap_tag) unstable++;
            end
            in_valid = 1'b1; in_data = 32'h0000_00F0; in_shamt = next_tag[4:0]; in_op = 2'b00;
            in_tag = next_tag[3:0];
            if (in_ready) next_tag++;
        end
        n_checks++; if (next_tag !== S1) $display("FAIL stall_fill_count: got %0d want %0d", next_tag, S1); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_full: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (have_snap !== 1) $display("FAIL stall_out_valid: got %0d want 1", have_snap); else n_pass++;
        n_checks++; if (unstable !== 0) $display("FAIL stall_out_stable: got %0d changes want 0", unstable); else n_pass++;
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_in_ready_comb: got %b want 1", in_ready); else n_pass++;
        cnt = 0; bad = 0;
        for (int t = 0; t < 15; t++) begin
            if (out_valid) begin
                exp_tag = cnt[3:0];
                if (out_tag !== exp_tag || out_data !== (32'hF0 << cnt)) bad++;
                cnt++;
            end
            @(negedge clock);
        end
        n_checks++; if (cnt !== S1) $display("FAIL stall_drain_count: got %0d want %0d", cnt, S1); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL stall_drain_data: got %0d bad want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_in_flight();
        int waited, stale;
        @(negedge clock);
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            if (t > 0) @(negedge clock);
            in_valid = 1'b1; in_data = 32'h0000_0100; in_shamt = 5'd1; in_op = 2'b00; in_tag = 4'hC + t[3:0];
        end
        @(negedge clock);
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin @(negedge clock); waited++; end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_pre_out_valid: got %b want 1", out_valid); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL rst_async_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_tag !== 4'h0) $display("FAIL rst_async_out_tag: got %h want 0", out_tag); else n_pass++;
        @(negedge clock);
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready: got %b want 1", in_ready); else n_pass++;
        stale = 0;
        for (int t = 0; t < 12; t++) begin
            if (out_valid) stale++;
            @(negedge clock);
        end
        n_checks++; if (stale !== 0) $display("FAIL rst_stale_result: got %0d want 0", stale); else n_pass++;
    endtask

    task automatic test_width8();
        run_op8(8'h80, 3'd3, 2'b10, 4'h1);
        n_checks++; if (res8 !== 8'hF0) $display("FAIL w8_sra3_data: got %h want f0", res8); else n_pass++;
        n_checks++; if (lat8 !== S3) $display("FAIL w8_latency: got %0d want %0d", lat8, S3); else n_pass++;
        n_checks++; if (tag8 !== 4'h1) $display("FAIL w8_tag: got %h want 1", tag8); else n_pass++;
        run_op8(8'hB4, 3'd5, 2'b01, 4'h2);
        n_checks++; if (res8 !== 8'h05) $display("FAIL w8_srl5_data: got %h want 05", res8); else n_pass++;
        run_op8(8'hFF, 3'd7, 2'b00, 4'h3);
        n_checks++; if (res8 !== 8'h80) $display("FAIL w8_sll7_data: got %h want 80", res8); else n_pass++;
        run_op8(8'h81, 3'd1, 2'b11, 4'h4);
        n_checks++; if (res8 !== ROL8_EXP) $display("FAIL w8_rol1_data: got %h want %h", res8, ROL8_EXP); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = '0; in_tag8 = '0;
        out_ready8 = 1'b1;
        test_reset();
        test_latency();
        test_ops();
        test_rotate();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
